// File: rtl/fir_detect_qualifier_if.sv
// Event stream from the detect qualifier to its consumer.
//   out_valid : head event present (FIFO non-empty)
//   out_ready : consumer accepts the head event this cycle
//   out_stamp : stamp of the first high cycle of the head event's run
//   out_len   : run length of the head event, saturating
// master = qualifier side, slave = consumer side.
interface fir_detect_qualifier_if #(
    parameter int STAMP_W = 16,
    parameter int LEN_W   = 8
);
    logic               out_valid;
    logic               out_ready;
    logic [STAMP_W-1:0] out_stamp;
    logic [LEN_W-1:0]   out_len;

    modport master (output out_valid, output out_stamp, output out_len, input out_ready);
    modport slave  (input out_valid, input out_stamp, input out_len, output out_ready);
endinterface

// File: rtl/fir_detect_qualifier.sv
// Turns the 1-bit FIR threshold-detect stream into discrete, time-stamped
// detection events. Runs shorter than min_run are discarded; each qualified
// event is followed by a hold-off window in which y_in is ignored. Events
// are queued in a small FIFO and read out over a valid/ready handshake.
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   y_in      : detect bit, sampled every rising edge
//   min_run   : minimum qualifying run length (0 behaves as 1)
//   holdoff   : cycles y_in is ignored after a qualified event (0 = none)
//   clr_ovf   : synchronous clear of ovf (a same-cycle drop wins)
//   evt       : event stream (out_valid/out_ready/out_stamp/out_len)
//   ovf       : sticky, an event was dropped because the FIFO was full
//   fill      : current FIFO occupancy
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | waiting for y_in high
// S_RUN    | counting a high run; run end decides qualify/discard
// S_HOLDOFF| ignoring y_in for holdoff cycles after a qualified event
module fir_detect_qualifier #(
    parameter int DEPTH   = 4,
    parameter int STAMP_W = 16,
    parameter int LEN_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       y_in,
    input  logic [LEN_W-1:0]           min_run,
    input  logic [7:0]                 holdoff,
    input  logic                       clr_ovf,
    fir_detect_qualifier_if.master     evt,
    output logic                       ovf,
    output logic [$clog2(DEPTH):0]     fill
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLDOFF} state_t;

    state_t             state_q, state_d;
    logic [STAMP_W-1:0] stamp_q;
    logic [STAMP_W-1:0] start_q;
    logic [LEN_W-1:0]   len_q;
    logic [7:0]         hcnt_q;
    logic [LEN_W-1:0]   min_eff;
    logic               push;

    logic [STAMP_W+LEN_W-1:0] mem [DEPTH];
    logic [AW-1:0]            rd_ptr, wr_ptr;
    logic [AW:0]              fill_q;
    logic                     full, pop, wr_en;

    assign min_eff = (min_run == '0) ? LEN_W'(1) : min_run;
    // Run ends on the first low sample; min_run is only looked at here.
    assign push    = (state_q == S_RUN) && !y_in && (len_q >= min_eff);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (y_in) state_d = S_RUN;
            S_RUN:     if (!y_in) state_d = (push && holdoff != 8'd0) ? S_HOLDOFF : S_IDLE;
            S_HOLDOFF: if (hcnt_q == 8'd1) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Hold-off is a down-counter loaded at the push edge; terminal count 1
    // makes the window exactly holdoff cycles long.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stamp_q <= '0;
            start_q <= '0;
            len_q   <= '0;
            hcnt_q  <= '0;
        end else begin
            stamp_q <= stamp_q + 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (y_in) begin
                        start_q <= stamp_q;
                        len_q   <= LEN_W'(1);
                    end
                end
                S_RUN: begin
                    if (y_in && len_q != {LEN_W{1'b1}}) len_q <= len_q + 1'b1;
                    if (push) hcnt_q <= holdoff;
                end
                S_HOLDOFF: hcnt_q <= hcnt_q - 1'b1;
                default: ;
            endcase
        end
    end

    assign full  = (fill_q == (AW+1)'(DEPTH));
    assign pop   = evt.out_valid && evt.out_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {start_q, len_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            fill_q <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   fill_q <= fill_q + 1'b1;
                2'b01:   fill_q <= fill_q - 1'b1;
                default: fill_q <= fill_q;
            endcase
            if (push && full && !pop) ovf <= 1'b1;
            else if (clr_ovf)         ovf <= 1'b0;
        end
    end

    // Head is gated by valid so an empty FIFO presents zeros, not stale data.
    assign evt.out_valid = (fill_q != '0);
    assign {evt.out_stamp, evt.out_len} = evt.out_valid ? mem[rd_ptr] : '0;
    assign fill = fill_q;
endmodule
